// File: rtl/ph_sequencer.sv
// Sequencer for one PearsonHash instance: loads the 256-entry table from a key ROM,
// then shares the block-hash path between two requesters with round-robin arbitration and rekey support.
module ph_sequencer #(
  parameter int BLOCK_SIZE_IN_OCTETS = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  output logic [7:0]                        key_addr,
  input  logic [7:0]                        key_data,
  input  logic                              rekey,
  output logic                              loaded,
  input  logic                              req0_valid,
  input  logic                              req1_valid,
  input  logic [8*BLOCK_SIZE_IN_OCTETS-1:0] req0_block,
  input  logic [8*BLOCK_SIZE_IN_OCTETS-1:0] req1_block,
  output logic                              req0_ready,
  output logic                              req1_ready,
  output logic                              rsp0_valid,
  output logic                              rsp1_valid,
  output logic [7:0]                        rsp0_hash,
  output logic [7:0]                        rsp1_hash,
  output logic                              PH_write_enable,
  input  logic                              PH_write_ready,
  output logic [7:0]                        PH_idx_in,
  output logic [7:0]                        PH_key_byte_in,
  output logic                              PH_block_enable,
  input  logic                              PH_block_ready,
  output logic [8*BLOCK_SIZE_IN_OCTETS-1:0] PH_block_in,
  input  logic [7:0]                        PH_block_hash
);
  localparam int W = 8 * BLOCK_SIZE_IN_OCTETS;

  typedef enum logic [2:0] {
    S_LOAD_FETCH = 3'd0,
    S_LOAD_WRITE = 3'd1,
    S_LOAD_WAIT  = 3'd2,
    S_IDLE       = 3'd3,
    S_HASH_ISSUE = 3'd4,
    S_HASH_WAIT  = 3'd5
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [7:0]     r_idx;
  logic [7:0]     r_key_addr;
  logic           r_loaded;
  logic           r_rekey_pend;
  logic           r_last_grant;
  logic           r_grant;
  logic           r_we;
  logic           r_we_d;
  logic           r_be;
  logic           r_be_d;
  logic [7:0]     r_idx_in;
  logic [7:0]     r_key_byte;
  logic [W-1:0]   r_block_in;
  logic           r_ready0;
  logic           r_ready1;
  logic           r_rsp0;
  logic           r_rsp1;
  logic [7:0]     r_hash0;
  logic [7:0]     r_hash1;

  logic           w_wr_fire;
  logic           w_wr_done;
  logic           w_last_idx;
  logic           w_rekey_take;
  logic           w_grant_vld;
  logic           w_grant_id;
  logic           w_blk_fire;
  logic           w_hash_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_LOAD_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Strobes are registered, so ready is ignored both in the strobe cycle and the one after it.
  always_comb begin
    w_wr_fire    = (r_state == S_LOAD_WRITE) && PH_write_ready;
    w_wr_done    = (r_state == S_LOAD_WAIT) && PH_write_ready && !r_we && !r_we_d;
    w_last_idx   = (r_idx == 8'd255);
    w_rekey_take = (r_state == S_IDLE) && r_rekey_pend;
    w_grant_vld  = (r_state == S_IDLE) && !r_rekey_pend && (req0_valid || req1_valid);
    w_grant_id   = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
    w_blk_fire   = (r_state == S_HASH_ISSUE) && PH_block_ready;
    w_hash_done  = (r_state == S_HASH_WAIT) && PH_block_ready && !r_be && !r_be_d;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD_FETCH: w_next = S_LOAD_WRITE;
      S_LOAD_WRITE: if (w_wr_fire) w_next = S_LOAD_WAIT; else w_next = S_LOAD_WRITE;
      S_LOAD_WAIT: begin
        if (w_wr_done) w_next = w_last_idx ? S_IDLE : S_LOAD_FETCH;
        else w_next = S_LOAD_WAIT;
      end
      S_IDLE: begin
        if (w_rekey_take) w_next = S_LOAD_FETCH;
        else if (w_grant_vld) w_next = S_HASH_ISSUE;
        else w_next = S_IDLE;
      end
      S_HASH_ISSUE: if (w_blk_fire) w_next = S_HASH_WAIT; else w_next = S_HASH_ISSUE;
      S_HASH_WAIT: if (w_hash_done) w_next = S_IDLE; else w_next = S_HASH_WAIT;
      default: w_next = S_LOAD_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx        <= 8'd0;
      r_key_addr   <= 8'd0;
      r_loaded     <= 1'b0;
      r_rekey_pend <= 1'b0;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_we         <= 1'b0;
      r_we_d       <= 1'b0;
      r_be         <= 1'b0;
      r_be_d       <= 1'b0;
      r_idx_in     <= 8'd0;
      r_key_byte   <= 8'd0;
      r_block_in   <= '0;
      r_ready0     <= 1'b0;
      r_ready1     <= 1'b0;
      r_rsp0       <= 1'b0;
      r_rsp1       <= 1'b0;
      r_hash0      <= 8'd0;
      r_hash1      <= 8'd0;
    end else begin
      r_we         <= w_wr_fire;
      r_we_d       <= r_we;
      r_be         <= w_blk_fire;
      r_be_d       <= r_be;
      r_rekey_pend <= rekey | (r_rekey_pend & ~w_rekey_take);
      r_ready0     <= w_grant_vld & ~w_grant_id;
      r_ready1     <= w_grant_vld & w_grant_id;
      r_rsp0       <= w_hash_done & ~r_grant;
      r_rsp1       <= w_hash_done & r_grant;
      if (w_wr_fire) begin
        r_idx_in   <= r_idx;
        r_key_byte <= key_data;
      end
      if (w_wr_done) begin
        r_idx    <= w_last_idx ? 8'd0 : r_idx + 8'd1;
        r_loaded <= w_last_idx;
        if (!w_last_idx) r_key_addr <= r_idx + 8'd1;
      end else if (w_rekey_take) begin
        r_idx      <= 8'd0;
        r_loaded   <= 1'b0;
        r_key_addr <= 8'd0;
      end
      if (w_grant_vld) begin
        r_block_in   <= w_grant_id ? req1_block : req0_block;
        r_grant      <= w_grant_id;
        r_last_grant <= w_grant_id;
      end
      if (w_hash_done) begin
        if (r_grant) r_hash1 <= PH_block_hash;
        else r_hash0 <= PH_block_hash;
      end
    end
  end

  assign key_addr        = r_key_addr;
  assign loaded          = r_loaded;
  assign req0_ready      = r_ready0;
  assign req1_ready      = r_ready1;
  assign rsp0_valid      = r_rsp0;
  assign rsp1_valid      = r_rsp1;
  assign rsp0_hash       = r_hash0;
  assign rsp1_hash       = r_hash1;
  assign PH_write_enable = r_we;
  assign PH_idx_in       = r_idx_in;
  assign PH_key_byte_in  = r_key_byte;
  assign PH_block_enable = r_be;
  assign PH_block_in     = r_block_in;

endmodule
